// File: rtl/tile_operand_feeder_pkg.sv
// Shared definitions for the tile operand feeder: legal modes and FSM states.
package tile_operand_feeder_pkg;

  localparam logic [2:0] MODE_MAC   = 3'b000;
  localparam logic [2:0] MODE_OUTER = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_e;

  // Only MAC and OUTER are understood by the downstream arrays.
  function automatic logic is_legal_mode(input logic [2:0] m);
    return (m == MODE_MAC) || (m == MODE_OUTER);
  endfunction

endpackage

// File: rtl/tile_operand_feeder.sv
// Tile operand feeder: accepts a command, streams cmd_len operand beats into the
// 4-array pipeline with one cycle of latency, then waits for the pipeline to drain.
module tile_operand_feeder
  import tile_operand_feeder_pkg::*;
#(
  parameter int TILE_SIZE    = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int LEN_WIDTH    = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    cmd_valid,
  output logic                                                    cmd_ready,
  input  logic [2:0]                                              cmd_mode,
  input  logic [LEN_WIDTH-1:0]                                    cmd_len,
  input  logic                                                    op_valid,
  output logic                                                    op_ready,
  input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] op_A0_mat,
  input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] op_A1_mat,
  input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] op_A2_mat,
  input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] op_A3_mat,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                op_B0_vec,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                op_B1_vec,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                op_B2_vec,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                op_B3_vec,
  output logic [2:0]                                              mode,
  output logic                                                    valid_in,
  output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A0_mat,
  output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A1_mat,
  output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A2_mat,
  output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A3_mat,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                B0_vec,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                B1_vec,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                B2_vec,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                B3_vec,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    cmd_err
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  typedef logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] mat_t;
  typedef logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]                vec_t;

  feeder_state_e        state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [LEN_WIDTH-1:0] beat_inc;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 valid_in_q, valid_in_d;
  logic                 done_q, done_d;
  logic                 cmd_err_q, cmd_err_d;
  mat_t                 a_q [4];
  mat_t                 a_d [4];
  vec_t                 b_q [4];
  vec_t                 b_d [4];

  // The last beat is seen when beat_q is len-1, so the increment never wraps
  // even for a full-scale length.
  assign beat_inc = beat_q + LEN_WIDTH'(1);

  // Next-state, counters and operand capture; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    beat_d     = beat_q;
    drain_d    = drain_q;
    valid_in_d = 1'b0;
    done_d     = 1'b0;
    cmd_err_d  = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!is_legal_mode(cmd_mode)) begin
            cmd_err_d = 1'b1;
            done_d    = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = cmd_mode;
            len_d   = cmd_len;
            beat_d  = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (op_valid) begin
          valid_in_d = 1'b1;
          a_d[0]     = op_A0_mat;
          a_d[1]     = op_A1_mat;
          a_d[2]     = op_A2_mat;
          a_d[3]     = op_A3_mat;
          b_d[0]     = op_B0_vec;
          b_d[1]     = op_B1_vec;
          b_d[2]     = op_B2_vec;
          b_d[3]     = op_B3_vec;
          beat_d     = beat_inc;
          if (beat_inc == len_q) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything including operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_MAC;
      len_q      <= '0;
      beat_q     <= '0;
      drain_q    <= '0;
      valid_in_q <= 1'b0;
      done_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      valid_in_q <= valid_in_d;
      done_q     <= done_d;
      cmd_err_q  <= cmd_err_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign op_ready  = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign mode      = mode_q;
  assign valid_in  = valid_in_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;
  assign A0_mat    = a_q[0];
  assign A1_mat    = a_q[1];
  assign A2_mat    = a_q[2];
  assign A3_mat    = a_q[3];
  assign B0_vec    = b_q[0];
  assign B1_vec    = b_q[1];
  assign B2_vec    = b_q[2];
  assign B3_vec    = b_q[3];

endmodule

// File: tb/tb_tile_operand_feeder.sv
// Bench for tile_operand_feeder: directed commands with random operand data and
// random bubbles, checked against a command-level model of beats and drain timing.
module tb_tile_operand_feeder;
  import tile_operand_feeder_pkg::*;

  localparam int TS = 4;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int DC = 8;

  typedef logic signed [TS-1:0][TS-1:0][DW-1:0] mat_t;
  typedef logic signed [TS-1:0][DW-1:0]         vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_mode;
  logic [LW-1:0] cmd_len;
  logic          op_valid;
  logic          op_ready;
  mat_t          op_a [4];
  vec_t          op_b [4];
  logic [2:0]    mode;
  logic          valid_in;
  mat_t          a_out [4];
  vec_t          b_out [4];
  logic          busy, done, cmd_err;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] exp_mode;
  mat_t       exp_a [4];
  vec_t       exp_b [4];

  tile_operand_feeder #(
    .TILE_SIZE(TS), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_A0_mat(op_a[0]), .op_A1_mat(op_a[1]), .op_A2_mat(op_a[2]), .op_A3_mat(op_a[3]),
    .op_B0_vec(op_b[0]), .op_B1_vec(op_b[1]), .op_B2_vec(op_b[2]), .op_B3_vec(op_b[3]),
    .mode(mode), .valid_in(valid_in),
    .A0_mat(a_out[0]), .A1_mat(a_out[1]), .A2_mat(a_out[2]), .A3_mat(a_out[3]),
    .B0_vec(b_out[0]), .B1_vec(b_out[1]), .B2_vec(b_out[2]), .B3_vec(b_out[3]),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_operands(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("%s A%0d", tag, i), a_out[i], exp_a[i]);
      check_output($sformatf("%s B%0d", tag, i), b_out[i], exp_b[i]);
    end
  endtask

  task automatic check_status(input string tag, input bit e_busy, input bit e_opr,
                              input bit e_valid, input bit e_done, input bit e_err);
    check_output({tag, " busy"}, busy, e_busy);
    check_output({tag, " cmd_ready"}, cmd_ready, !e_busy);
    check_output({tag, " op_ready"}, op_ready, e_opr);
    check_output({tag, " valid_in"}, valid_in, e_valid);
    check_output({tag, " done"}, done, e_done);
    check_output({tag, " cmd_err"}, cmd_err, e_err);
    check_output({tag, " mode"}, mode, exp_mode);
  endtask

  task automatic randomize_ops();
    logic [255:0] t;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
      op_a[i] = t;
      op_b[i] = {$urandom, $urandom};
    end
  endtask

  task automatic clear_model();
    exp_mode = 3'b000;
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
  endtask

  // Present one command in an idle cycle and check the immediate response.
  task automatic apply_stimulus(input logic [2:0] m, input logic [LW-1:0] len);
    bit legal;
    legal     = (m == 3'b000) || (m == 3'b011);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = len;
    op_valid  = 1'b0;
    check_output("cmd_ready before accept", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    if (!legal) begin
      check_status("illegal mode", 0, 0, 0, 1, 1);
      tick();
      check_status("illegal mode after", 0, 0, 0, 0, 0);
    end else if (len == 0) begin
      check_status("zero len", 0, 0, 0, 1, 0);
      tick();
      check_status("zero len after", 0, 0, 0, 0, 0);
    end else begin
      exp_mode = m;
      check_status("accepted", 1, 1, 0, 0, 0);
    end
  endtask

  // Feed operand beats until len are taken, then follow the drain to done.
  // pat_len>0 gives an explicit op_valid pattern (LSB first), else random bubbles.
  task automatic feed_and_drain(input logic [LW-1:0] len, input logic [31:0] pat,
                                input int pat_len, input int bubble_pct,
                                input bit chain, input logic [2:0] chain_mode,
                                input logic [LW-1:0] chain_len);
    int taken = 0;
    int cyc   = 0;
    bit v;
    while (taken < int'(len) && cyc < 4 * int'(len) + 64) begin
      randomize_ops();
      if (pat_len > 0) v = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             v = ($urandom_range(99) >= bubble_pct);
      op_valid = v;
      check_output("op_ready issuing", op_ready, 1'b1);
      tick();
      cyc++;
      if (v) begin
        taken++;
        exp_a = op_a;
        exp_b = op_b;
      end
      check_output("valid_in per beat", valid_in, v);
      check_output("mode stable issue", mode, exp_mode);
      check_operands("beat");
    end
    if (taken < int'(len)) check_output("beat budget", taken, len);
    check_output("op_ready after last beat", op_ready, 1'b0);
    check_output("done after last beat", done, 1'b0);
    cmd_valid = chain;
    cmd_mode  = chain_mode;
    cmd_len   = chain_len;
    for (int n = 1; n <= DC; n++) begin
      op_valid = $urandom_range(1);
      tick();
      check_status($sformatf("drain %0d", n), n < DC, 0, 0, n == DC, 0);
      check_operands("drain hold");
    end
    op_valid = 1'b0;
    if (chain) begin
      tick();
      cmd_valid = 1'b0;
      exp_mode  = chain_mode;
      check_status("chained accept", 1, 1, 0, 0, 0);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]    m;
    logic [LW-1:0] l;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 3'b000;
    cmd_len   = '0;
    op_valid  = 1'b0;
    randomize_ops();
    clear_model();
    tick();
    tick();
    check_status("reset", 0, 0, 0, 0, 0);
    check_operands("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] MAC length 3, no bubbles");
    apply_stimulus(MODE_MAC, 8'd3);
    feed_and_drain(8'd3, 32'd0, 0, 0, 0, 3'b000, 8'd0);

    $display("[TB] OUTER length 4, pattern 1,0,1,1,1");
    apply_stimulus(MODE_OUTER, 8'd4);
    feed_and_drain(8'd4, 32'b11101, 5, 0, 0, 3'b000, 8'd0);

    $display("[TB] illegal mode and zero length");
    apply_stimulus(3'b101, 8'd7);
    apply_stimulus(MODE_MAC, 8'd0);

    $display("[TB] reset in the middle of issue");
    apply_stimulus(MODE_MAC, 8'd5);
    for (int k = 0; k < 2; k++) begin
      randomize_ops();
      op_valid = 1'b1;
      tick();
      exp_a = op_a;
      exp_b = op_b;
      check_output("pre-reset valid_in", valid_in, 1'b1);
      check_operands("pre-reset");
    end
    rst_n    = 1'b0;
    op_valid = 1'b1;
    tick();
    clear_model();
    check_status("mid reset", 0, 0, 0, 0, 0);
    check_operands("mid reset");
    rst_n    = 1'b1;
    op_valid = 1'b0;
    for (int k = 0; k < DC + 2; k++) begin
      tick();
      check_output("no done after abort", done, 1'b0);
      check_output("idle after abort", busy, 1'b0);
    end
    apply_stimulus(MODE_MAC, 8'd1);
    feed_and_drain(8'd1, 32'd0, 0, 0, 0, 3'b000, 8'd0);

    $display("[TB] back-to-back commands");
    apply_stimulus(MODE_OUTER, 8'd2);
    feed_and_drain(8'd2, 32'd0, 0, 0, 1, MODE_MAC, 8'd3);
    feed_and_drain(8'd3, 32'd0, 0, 30, 0, 3'b000, 8'd0);

    $display("[TB] random commands");
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(3))
        0: m = MODE_MAC;
        1: m = MODE_OUTER;
        2: m = MODE_OUTER;
        default: m = 3'($urandom_range(7));
      endcase
      l = LW'($urandom_range(12));
      apply_stimulus(m, l);
      if (((m == 3'b000) || (m == 3'b011)) && l != 0)
        feed_and_drain(l, 32'd0, 0, 40, 0, 3'b000, 8'd0);
      tick();
    end

    $display("[TB] full-scale length 255");
    apply_stimulus(MODE_MAC, 8'd255);
    feed_and_drain(8'd255, 32'd0, 0, 20, 0, 3'b000, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
